// File: rtl/mixer_pkg.sv
// mixer_pkg: shared FSM states, gain width and saturation helper for echo_mixer
package mixer_pkg;
  localparam int GAIN_W = 7;
  typedef enum logic [2:0] {IDLE, ACCUM, MASTER, RD_K, RD_2K, OUT} state_t;
  // Clamp a wide signed value to the w-bit two's-complement range; w is always a constant at the call site
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/delay_ram.sv
// delay_ram: single-port synchronous-read sample buffer, one access per cycle
module delay_ram #(
  parameter int DEPTH = 1024,
  parameter int W = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  // Contents are never cleared; readers mask unwritten locations by fill count
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/echo_mixer.sv
// echo_mixer: sequential multi-voice mixer with master gain and two-tap feed-forward echo
module echo_mixer import mixer_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int SAMPLE_W = 24,
  parameter int DEPTH = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sample_tick,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]      samples,
  input  logic [NUM_CH-1:0][GAIN_W-1:0]        ch_gain,
  input  logic [GAIN_W-1:0]                    master_vol,
  input  logic [$clog2(DEPTH)-1:0]             delay_k,
  input  logic [GAIN_W-1:0]                    tap_gain_k,
  input  logic [GAIN_W-1:0]                    tap_gain_2k,
  input  logic                                 echo_en,
  output logic signed [SAMPLE_W-1:0]           mixed_sample,
  output logic                                 out_valid,
  output logic                                 busy,
  output logic                                 overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int MUL_W = ACC_W + GAIN_W + 1;

  state_t                     r_state;
  logic [CH_W-1:0]            r_ch;
  logic signed [SAMPLE_W-1:0] r_smp [NUM_CH];
  logic [GAIN_W-1:0]          r_gain [NUM_CH];
  logic [GAIN_W-1:0]          r_mvol;
  logic [GAIN_W-1:0]          r_tgk;
  logic [GAIN_W-1:0]          r_tg2k;
  logic [AW-1:0]              r_k;
  logic                       r_echo;
  logic [AW-1:0]              r_wr_ptr;
  logic [AW:0]                r_fill;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [SAMPLE_W-1:0] r_dry;
  logic signed [ACC_W:0]      r_wet;

  logic signed [ACC_W-1:0]    w_mul_a;
  logic [GAIN_W-1:0]          w_mul_b;
  logic signed [MUL_W-1:0]    w_prod;
  logic signed [ACC_W:0]      w_scaled;
  logic signed [SAMPLE_W-1:0] w_dry;
  logic signed [SAMPLE_W-1:0] w_mix;
  logic signed [SAMPLE_W-1:0] w_rdata;
  logic [AW-1:0]              w_addr;
  logic                       w_we;
  logic                       w_vk;
  logic                       w_v2k;
  logic                       w_accept;

  assign w_accept = sample_tick && r_state == IDLE;
  assign busy = r_state != IDLE;

  // One shared sample-by-gain multiplier: voices in ACCUM, master in MASTER, echo taps in RD_K/RD_2K
  assign w_mul_a = r_state == ACCUM ? ACC_W'(r_smp[r_ch]) : r_state == MASTER ? r_acc : ACC_W'(w_rdata);
  assign w_mul_b = r_state == ACCUM ? r_gain[r_ch] : r_state == MASTER ? r_mvol : r_state == RD_K ? r_tgk : r_tg2k;
  assign w_prod = MUL_W'(w_mul_a) * MUL_W'($signed({1'b0, w_mul_b}));
  assign w_scaled = (ACC_W + 1)'(w_prod >>> GAIN_W);
  assign w_dry = SAMPLE_W'(sat(64'(w_scaled), SAMPLE_W));
  assign w_mix = SAMPLE_W'(sat(64'(r_dry) + 64'(r_wet) + (w_v2k ? 64'(w_scaled) : 64'sd0), SAMPLE_W));

  // A tap is live only when echo is on, k is nonzero and that many samples have already been stored
  assign w_vk = r_echo && r_k != '0 && {1'b0, r_k} <= r_fill;
  assign w_v2k = r_echo && r_k != '0 && !r_k[AW-1] && {r_k, 1'b0} <= r_fill;

  // Reads are issued one cycle early (k in MASTER, 2k in RD_K) so the RD_2K cycle is free for the dry write
  assign w_addr = r_state == MASTER ? r_wr_ptr - r_k : r_state == RD_K ? r_wr_ptr - {r_k[AW-2:0], 1'b0} : r_wr_ptr;
  assign w_we = r_state == RD_2K;

  delay_ram #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (r_dry),
    .o_rdata (w_rdata)
  );

  // Snapshot voices and controls on an accepted tick so the sequence sees a stable frame
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_smp[i] <= samples[i];
        r_gain[i] <= ch_gain[i];
      end
      r_mvol <= master_vol;
      r_tgk <= tap_gain_k;
      r_tg2k <= tap_gain_2k;
      r_k <= delay_k;
      r_echo <= echo_en;
    end
  end

  // Mix sequencer: accumulate voices, apply master, fetch taps, write dry, publish result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch <= '0;
      r_acc <= '0;
      r_dry <= '0;
      r_wet <= '0;
      r_wr_ptr <= '0;
      r_fill <= '0;
      mixed_sample <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_valid <= r_state == RD_2K;
      if (sample_tick && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: if (sample_tick) begin
          r_state <= ACCUM;
          r_ch <= '0;
          r_acc <= '0;
        end
        ACCUM: begin
          r_acc <= r_acc + w_scaled[ACC_W-1:0];
          r_ch <= r_ch + 1'b1;
          if (r_ch == CH_W'(NUM_CH - 1)) r_state <= MASTER;
        end
        MASTER: begin
          r_dry <= w_dry;
          r_state <= RD_K;
        end
        RD_K: begin
          r_wet <= w_vk ? w_scaled : '0;
          r_state <= RD_2K;
        end
        RD_2K: begin
          mixed_sample <= w_mix;
          r_state <= OUT;
        end
        OUT: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (!r_fill[AW]) r_fill <= r_fill + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_echo_mixer.sv
// tb_echo_mixer: directed self-checking bench for echo_mixer
module tb_echo_mixer;
  localparam int NUM_CH = 4;
  localparam int SW = 24;
  localparam int DEPTH = 1024;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         sample_tick;
  logic [NUM_CH-1:0][SW-1:0]    samples;
  logic [NUM_CH-1:0][6:0]       ch_gain;
  logic [6:0]                   master_vol;
  logic [9:0]                   delay_k;
  logic [6:0]                   tap_gain_k;
  logic [6:0]                   tap_gain_2k;
  logic                         echo_en;
  logic signed [SW-1:0]         mixed_sample;
  logic                         out_valid;
  logic                         busy;
  logic                         overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  echo_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .samples      (samples),
    .ch_gain      (ch_gain),
    .master_vol   (master_vol),
    .delay_k      (delay_k),
    .tap_gain_k   (tap_gain_k),
    .tap_gain_2k  (tap_gain_2k),
    .echo_en      (echo_en),
    .mixed_sample (mixed_sample),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic set_all(input logic [SW-1:0] s, input logic [6:0] g);
    for (int i = 0; i < NUM_CH; i++) begin
      samples[i] = s;
      ch_gain[i] = g;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic fire(output logic signed [SW-1:0] res, output int lat);
    res = 'x;
    lat = 0;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (out_valid) begin
        lat = n;
        res = mixed_sample;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_tick = 1'b0; echo_en = 1'b0;
    delay_k = '0; tap_gain_k = '0; tap_gain_2k = '0; master_vol = '0;
    set_all('0, '0);
    repeat (3) @(negedge clk);
    n_cmp++; if (mixed_sample !== 0) begin n_bad++; $display("FAIL reset mixed_sample: got %0d want 0", mixed_sample); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset overrun: got %b want 0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_dry_mix();
    logic signed [SW-1:0] res;
    int lat;
    set_all(24'd1000, 7'd64); master_vol = 7'd127; echo_en = 1'b0;
    fire(res, lat);
    n_cmp++; if (res !== 1984) begin n_bad++; $display("FAIL dry_mix value: got %0d want 1984", res); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL dry_mix latency: got %0d want 8", lat); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dry_mix busy_at_out: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dry_mix pulse_width: out_valid %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dry_mix busy_after: got %b want 0", busy); end
    n_cmp++; if (mixed_sample !== 1984) begin n_bad++; $display("FAIL dry_mix hold: got %0d want 1984", mixed_sample); end
    samples[0] = 24'd100;  ch_gain[0] = 7'd127;
    samples[1] = -24'sd201; ch_gain[1] = 7'd64;
    samples[2] = 24'd3000; ch_gain[2] = 7'd32;
    samples[3] = 24'd40;   ch_gain[3] = 7'd0;
    master_vol = 7'd64;
    fire(res, lat);
    n_cmp++; if (res !== 374) begin n_bad++; $display("FAIL per_voice_gain value: got %0d want 374", res); end
  endtask

  task automatic test_saturation();
    logic signed [SW-1:0] res;
    int lat;
    set_all(24'h7FFFFF, 7'd127); master_vol = 7'd127;
    fire(res, lat);
    n_cmp++; if (res !== 8388607) begin n_bad++; $display("FAIL sat_pos value: got %0d want 8388607", res); end
    set_all(24'h800000, 7'd127);
    fire(res, lat);
    n_cmp++; if (res !== -8388608) begin n_bad++; $display("FAIL sat_neg value: got %0d want -8388608", res); end
  endtask

  task automatic test_echo_impulse();
    logic signed [SW-1:0] res;
    int lat;
    int exp_v [8] = '{984, 0, 0, 492, 0, 0, 246, 0};
    pulse_reset();
    echo_en = 1'b1; delay_k = 10'd3; tap_gain_k = 7'd64; tap_gain_2k = 7'd32; master_vol = 7'd127;
    for (int n = 0; n < 8; n++) begin
      set_all('0, 7'd127);
      if (n == 0) samples[0] = 24'd1000;
      fire(res, lat);
      n_cmp++; if (res !== exp_v[n]) begin n_bad++; $display("FAIL echo_impulse[%0d]: got %0d want %0d", n, res, exp_v[n]); end
    end
  endtask

  task automatic test_overrun();
    logic signed [SW-1:0] res;
    int lat;
    int pulses;
    echo_en = 1'b0; master_vol = 7'd127;
    set_all(24'd1000, 7'd64);
    res = 'x; lat = 0;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); sample_tick = 1'b1; set_all(24'd5, 7'd127);
    @(negedge clk); sample_tick = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun set: got %b want 1", overrun); end
    for (int n = 4; n <= 30; n++) begin
      if (out_valid) begin lat = n; res = mixed_sample; break; end
      @(negedge clk);
    end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL overrun latency: got %0d want 8", lat); end
    n_cmp++; if (res !== 1984) begin n_bad++; $display("FAIL overrun value: got %0d want 1984", res); end
    sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tick_in_out busy: got %b want 0", busy); end
    pulses = 0;
    repeat (15) begin @(negedge clk); if (out_valid) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL tick_in_out pulses: got %0d want 0", pulses); end
    set_all(24'd1000, 7'd64);
    fire(res, lat);
    n_cmp++; if (res !== 1984 || lat !== 8) begin n_bad++; $display("FAIL after_overrun: got %0d lat %0d want 1984 lat 8", res, lat); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    logic signed [SW-1:0] res;
    int lat;
    int pulses;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_mid overrun: got %b want 0", overrun); end
    n_cmp++; if (mixed_sample !== 0) begin n_bad++; $display("FAIL reset_mid mixed_sample: got %0d want 0", mixed_sample); end
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (15) begin @(negedge clk); if (out_valid) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL reset_mid pulses: got %0d want 0", pulses); end
    echo_en = 1'b1; delay_k = 10'd1; tap_gain_k = 7'd127; tap_gain_2k = 7'd127; master_vol = 7'd127;
    set_all('0, 7'd127); samples[0] = 24'd1000;
    fire(res, lat);
    n_cmp++; if (res !== 984 || lat !== 8) begin n_bad++; $display("FAIL reset_mid first: got %0d lat %0d want 984 lat 8", res, lat); end
    set_all('0, 7'd127);
    fire(res, lat);
    n_cmp++; if (res !== 976) begin n_bad++; $display("FAIL reset_mid second: got %0d want 976", res); end
  endtask

  task automatic test_long_delay();
    logic signed [SW-1:0] res;
    int lat;
    int nonzero;
    pulse_reset();
    echo_en = 1'b1; delay_k = 10'd600; tap_gain_k = 7'd64; tap_gain_2k = 7'd32; master_vol = 7'd127;
    set_all('0, 7'd127); samples[0] = 24'd1000;
    fire(res, lat);
    n_cmp++; if (res !== 984) begin n_bad++; $display("FAIL long_delay first: got %0d want 984", res); end
    set_all('0, 7'd127);
    nonzero = 0;
    for (int n = 1; n < 600; n++) begin
      fire(res, lat);
      if (res !== 0) nonzero++;
    end
    n_cmp++; if (nonzero !== 0) begin n_bad++; $display("FAIL long_delay early_taps: %0d nonzero outputs want 0", nonzero); end
    fire(res, lat);
    n_cmp++; if (res !== 492 || lat !== 8) begin n_bad++; $display("FAIL long_delay tap_k: got %0d lat %0d want 492 lat 8", res, lat); end
    fire(res, lat);
    n_cmp++; if (res !== 0) begin n_bad++; $display("FAIL long_delay after_tap: got %0d want 0", res); end
  endtask

  initial begin
    test_reset();
    test_dry_mix();
    test_saturation();
    test_echo_impulse();
    test_overrun();
    test_reset_mid();
    test_long_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
